// File: rtl/mpmodred.sv
// mpmodred -- modular-reduction sequencer wrapped around the 1030-bit adder.
//
// Performs the final conditional subtraction of the Montgomery datapath,
// result = a mod m for a < 2m. When MPMODRED_ADD_EN is defined it can also
// compute (a + b) mod m, given a, b < m. A start/done handshake wraps each
// operation, and only one operation runs at a time.
//
// Configuration macro: MPMODRED_ADD_EN (adds the op_add port and the add phase)
//
// Ports:
//   clk     in   1     clock, rising edge
//   reset   in   1     synchronous active-high reset (also resets the adder)
//   start   in   1     operation request, sampled only when idle
//   in_a    in   1030  operand a
//   in_b    in   1030  operand b (add mode only)
//   in_m    in   1030  modulus m, m < 2^1029
//   op_add  in   1     1 = (a+b) mod m   [MPMODRED_ADD_EN only]
//   busy    out  1     operation in flight
//   done    out  1     one-cycle pulse when result updates
//   result  out  1030  reduced value, held until the next done

// Adder with one registered stage: operands presented in cycle N give the
// sum/difference in cycle N+1. Bit 1030 is the carry (add) or borrow (sub).
module mpadderD (
    input  logic          clk,
    input  logic          reset,
    input  logic [1029:0] in_a,
    input  logic [1029:0] in_b,
    input  logic          subtract,
    output logic [1030:0] result
);

    always_ff @(posedge clk) begin
        if (reset)
            result <= '0;
        else if (subtract)
            result <= {1'b0, in_a} - {1'b0, in_b};
        else
            result <= {1'b0, in_a} + {1'b0, in_b};
    end

endmodule

module mpmodred (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1029:0] in_a,
    input  logic [1029:0] in_b,
    input  logic [1029:0] in_m,
`ifdef MPMODRED_ADD_EN
    input  logic          op_add,
`endif
    output logic          busy,
    output logic          done,
    output logic [1029:0] result
);

`ifdef MPMODRED_ADD_EN
    typedef enum logic [2:0] {
        IDLE,
        ADD_ISSUE,
        ADD_WAIT,
        SUB_ISSUE,
        SUB_WAIT
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        SUB_ISSUE,
        SUB_WAIT
    } state_t;
`endif

    state_t        state;
    state_t        state_next;

    logic [1029:0] a_reg;
    logic [1029:0] m_reg;
`ifdef MPMODRED_ADD_EN
    logic [1029:0] b_reg;
`else
    logic          unused_in_b;
    assign unused_in_b = ^in_b;
`endif

    logic [1029:0] add_a;
    logic [1029:0] add_b;
    logic          add_sub;
    logic [1030:0] add_res;

    mpadderD u_adder (
        .clk      (clk),
        .reset    (reset),
        .in_a     (add_a),
        .in_b     (add_b),
        .subtract (add_sub),
        .result   (add_res)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Adder operands are only non-zero in the ISSUE states.
    always_comb begin
        state_next = state;
        add_a      = '0;
        add_b      = '0;
        add_sub    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MPMODRED_ADD_EN
                    state_next = op_add ? ADD_ISSUE : SUB_ISSUE;
`else
                    state_next = SUB_ISSUE;
`endif
                end
            end
`ifdef MPMODRED_ADD_EN
            ADD_ISSUE: begin
                add_a      = a_reg;
                add_b      = b_reg;
                state_next = ADD_WAIT;
            end
            ADD_WAIT: begin
                state_next = SUB_ISSUE;
            end
`endif
            SUB_ISSUE: begin
                add_a      = a_reg;
                add_b      = m_reg;
                add_sub    = 1'b1;
                state_next = SUB_WAIT;
            end
            SUB_WAIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg  <= '0;
            m_reg  <= '0;
`ifdef MPMODRED_ADD_EN
            b_reg  <= '0;
`endif
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= in_a;
                        m_reg <= in_m;
`ifdef MPMODRED_ADD_EN
                        b_reg <= in_b;
`endif
                    end
                end
`ifdef MPMODRED_ADD_EN
                // Sum fits in 1030 bits because a, b < m < 2^1029.
                ADD_WAIT: begin
                    a_reg <= add_res[1029:0];
                end
`endif
                // Borrow set means a < m, so a is already reduced.
                SUB_WAIT: begin
                    result <= add_res[1030] ? a_reg : add_res[1029:0];
                    done   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpmodred.sv
module tb_mpmodred;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1029:0] in_a;
    logic [1029:0] in_b;
    logic [1029:0] in_m;
`ifdef MPMODRED_ADD_EN
    logic          op_add;
`endif
    logic          busy;
    logic          done;
    logic [1029:0] result;

    int unsigned   n_checks;
    int unsigned   n_fail;
    logic [1029:0] last_exp;

    mpmodred dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in_a   (in_a),
        .in_b   (in_b),
        .in_m   (in_m),
`ifdef MPMODRED_ADD_EN
        .op_add (op_add),
`endif
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1030:0] got, input logic [1030:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got[127:0]=%0h expected[127:0]=%0h", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Reference: plain modular arithmetic on wide integers.
    function automatic logic [1029:0] ref_mod(input logic [1029:0] a, input logic [1029:0] b,
                                              input logic [1029:0] m, input logic op);
        logic [1031:0] s;
        s = {2'b0, a};
        if (op) s = s + {2'b0, b};
        return 1030'(s % {2'b0, m});
    endfunction

    function automatic logic [1029:0] rand_wide();
        logic [1055:0] t;
        for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
        return t[1029:0];
    endfunction

    // Called at a falling edge; returns at the falling edge of the done cycle,
    // so a following call issues a back-to-back start.
    task automatic do_op(input string tag, input logic [1029:0] a, input logic [1029:0] b,
                         input logic [1029:0] m, input logic op, input bit inject);
        logic [1029:0] exp;
        int            lat;
        int            busy_cnt;
        bit            got;
        exp = ref_mod(a, b, m, op);
        lat = op ? 5 : 3;
        in_a = a;
        in_b = b;
        in_m = m;
`ifdef MPMODRED_ADD_EN
        op_add = op;
`endif
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        got      = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (inject && cyc == 1) begin
                start = 1'b1;
                in_a  = ~a;
                in_b  = ~b;
                in_m  = 1030'd1;
            end
            if (inject && cyc == 2) begin
                start = 1'b0;
                in_a  = a;
                in_b  = b;
                in_m  = m;
            end
            if (busy) busy_cnt++;
            if (done) begin
                check({tag, " latency"}, 1031'(cyc), 1031'(lat));
                check({tag, " busy cycles"}, 1031'(busy_cnt), 1031'(lat - 1));
                check({tag, " result"}, {1'b0, result}, {1'b0, exp});
                check({tag, " busy at done"}, {1030'b0, busy}, 1031'd0);
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check({tag, " done timeout"}, 1031'd0, 1031'd1);
        last_exp = exp;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, " idle done"}, {1030'b0, done}, 1031'd0);
        check({tag, " idle busy"}, {1030'b0, busy}, 1031'd0);
        check({tag, " result held"}, {1'b0, result}, {1'b0, last_exp});
    endtask

    initial begin
        logic [1029:0] ones;
        logic [1029:0] big_a;
        logic [1029:0] big_m;
        logic [1029:0] ra;
        logic [1029:0] rb;
        logic [1029:0] rm;
        logic [1030:0] two_m;
        logic          rop;
        bit            saw_done;

        n_checks = 0;
        n_fail   = 0;
        last_exp = '0;
        reset    = 1'b1;
        start    = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_m     = '0;
`ifdef MPMODRED_ADD_EN
        op_add   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset busy", {1030'b0, busy}, 1031'd0);
        check("reset done", {1030'b0, done}, 1031'd0);
        check("reset result", {1'b0, result}, 1031'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op("a5m7", 1030'd5, '0, 1030'd7, 1'b0, 1'b0);
        check("a5m7 literal", {1'b0, result}, 1031'd5);
        idle_check("a5m7");
        do_op("a9m7", 1030'd9, '0, 1030'd7, 1'b0, 1'b0);
        check("a9m7 literal", {1'b0, result}, 1031'd2);
        idle_check("a9m7");

        ones = '0;
        ones[1028:0] = '1;
        do_op("ones", ones, '0, ones, 1'b0, 1'b0);
        check("ones literal", {1'b0, result}, 1031'd0);
        idle_check("ones");

        big_a = '0;
        big_a[1029] = 1'b1;
        big_a = big_a + 1030'd3;
        big_m = ones;
        do_op("carry", big_a, '0, big_m, 1'b0, 1'b0);
        check("carry literal", {1'b0, result}, 1031'd4);
        idle_check("carry");

`ifdef MPMODRED_ADD_EN
        do_op("add654", 1030'd6, 1030'd5, 1030'd7, 1'b1, 1'b0);
        check("add654 literal", {1'b0, result}, 1031'd4);
        idle_check("add654");
        do_op("add235", 1030'd2, 1030'd3, 1030'd7, 1'b1, 1'b0);
        check("add235 literal", {1'b0, result}, 1031'd5);
        idle_check("add235");
        do_op("add inject", 1030'd4, 1030'd6, 1030'd9, 1'b1, 1'b1);
        idle_check("add inject");
`endif

        do_op("inject", 1030'd12, '0, 1030'd7, 1'b0, 1'b1);
        check("inject literal", {1'b0, result}, 1031'd5);
        idle_check("inject");

        do_op("b2b first", 1030'd9, '0, 1030'd7, 1'b0, 1'b0);
        do_op("b2b second", 1030'd3, '0, 1030'd7, 1'b0, 1'b0);
        idle_check("b2b");

        // Reset during SUB_WAIT: no done, outputs cleared next cycle.
        in_a  = 1030'd10;
        in_m  = 1030'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", {1030'b0, busy}, 1031'd0);
        check("abort done", {1030'b0, done}, 1031'd0);
        check("abort result", {1'b0, result}, 1031'd0);
        reset    = 1'b0;
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort no done", {1030'b0, saw_done}, 1031'd0);
        last_exp = '0;

        for (int n = 0; n < 40; n++) begin
            rm = rand_wide() >> $urandom_range(1, 1020);
            if (rm == '0) rm = 1030'd1;
            rop = 1'b0;
`ifdef MPMODRED_ADD_EN
            rop = 1'($urandom_range(0, 1));
`endif
            if (rop) begin
                ra = 1030'({1'b0, rand_wide()} % {1'b0, rm});
                rb = 1030'({1'b0, rand_wide()} % {1'b0, rm});
            end else begin
                two_m = {rm, 1'b0};
                rb    = rand_wide();
                case ($urandom_range(0, 4))
                    0:       ra = rm - 1030'd1;
                    1:       ra = rm;
                    2:       ra = 1030'(two_m - 1031'd1);
                    default: ra = 1030'({1'b0, rand_wide()} % two_m);
                endcase
            end
            do_op("random", ra, rb, rm, rop, 1'b0);
            if ($urandom_range(0, 1) == 0) idle_check("random");
        end
        idle_check("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
